pipe_addsub: RTL and testbench

- Parametrised, segmented, pipelined adder/subtractor for the Hunter_RV32 execute path and future multi-cycle datapaths.
- Splits an N-bit add/sub into SEGS carry-chained segments, one register stage per segment; carry ripples stage-to-stage, so clock period is set by N/SEGS bits of carry chain.
- Adds carry-in modes, Z/N/C/V flags and a valid/ready handshake with backpressure.

---
 rtl/pipe_addsub.sv | 168 ++++++++++++++++
 tb/tb_pipe_addsub.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Segmented, pipelined N-bit adder/subtractor: one W-bit carry-chained segment per register stage.
// Optional signed saturation on overflow is enabled by defining PIPE_ADDSUB_SAT_EN.
module pipe_addsub #(
  parameter int N    = 32,
  parameter int SEGS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   mode,
  input  logic         cin,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         vflag,
  output logic         zflag,
  output logic         nflag
);
  localparam int W = N / SEGS;

  logic         adv;
  logic [N-1:0] b_eff;
  logic         c0;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = mode[0] ? ~b : b;
  assign c0       = mode[1] ? cin : mode[0];

`ifndef PIPE_ADDSUB_SAT_EN
  logic unused_sat;
  assign unused_sat = sat;
`endif

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    localparam int RIN = N - k * W;

    logic [RIN-1:0]     a_i;
    logic [RIN-1:0]     b_i;
    logic               c_i;
    logic               z_i;
    logic               v_i;
    logic [W:0]         add;
    logic [(k+1)*W-1:0] s_raw;
    logic [(k+1)*W-1:0] s_n;
    logic [(k+1)*W-1:0] s_q;
    logic               z_raw;
    logic               z_n;
    logic               v_q;
    logic               c_q;
    logic               z_q;
`ifdef PIPE_ADDSUB_SAT_EN
    logic               sat_i;
`endif

    if (k == 0) begin : g_head
      assign a_i   = a;
      assign b_i   = b_eff;
      assign c_i   = c0;
      assign z_i   = 1'b1;
      assign v_i   = in_valid;
      assign s_raw = add[W-1:0];
`ifdef PIPE_ADDSUB_SAT_EN
      assign sat_i = sat;
`endif
    end else begin : g_body
      assign a_i   = g_stage[k-1].g_fwd.a_q;
      assign b_i   = g_stage[k-1].g_fwd.b_q;
      assign c_i   = g_stage[k-1].c_q;
      assign z_i   = g_stage[k-1].z_q;
      assign v_i   = g_stage[k-1].v_q;
      assign s_raw = {add[W-1:0], g_stage[k-1].s_q};
`ifdef PIPE_ADDSUB_SAT_EN
      assign sat_i = g_stage[k-1].g_fwd.sat_q;
`endif
    end

    assign add   = {1'b0, a_i[W-1:0]} + {1'b0, b_i[W-1:0]} + {{W{1'b0}}, c_i};
    assign z_raw = z_i && (add[W-1:0] == '0);

    if (k < SEGS - 1) begin : g_fwd
      // Only the operand bits of segments not yet added travel onward.
      logic [RIN-W-1:0] a_q;
      logic [RIN-W-1:0] b_q;
`ifdef PIPE_ADDSUB_SAT_EN
      logic             sat_q;
`endif

      assign s_n = s_raw;
      assign z_n = z_raw;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_i[RIN-1:W];
          b_q <= b_i[RIN-1:W];
        end
      end

`ifdef PIPE_ADDSUB_SAT_EN
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sat_q <= 1'b0;
        end else if (adv) begin
          sat_q <= sat_i;
        end
      end
`endif
    end else begin : g_last
      logic cm;
      logic ovf;
      logic vf_q;

      // Carry into the MSB is recovered from the sum bit: s = a ^ b ^ carry_in.
      assign cm  = a_i[W-1] ^ b_i[W-1] ^ add[W-1];
      assign ovf = cm ^ add[W];

`ifdef PIPE_ADDSUB_SAT_EN
      logic clamp;
      // On overflow both operands share a sign, so a's MSB picks the clamp direction.
      assign clamp = sat_i && ovf;
      assign s_n   = clamp ? {a_i[W-1], {(N-1){~a_i[W-1]}}} : s_raw;
      assign z_n   = z_raw && !clamp;
`else
      assign s_n = s_raw;
      assign z_n = z_raw;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vf_q <= 1'b0;
        end else if (adv) begin
          vf_q <= ovf;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        z_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        c_q <= add[W];
        z_q <= z_n;
        s_q <= s_n;
      end
    end
  end

  assign out_valid = g_stage[SEGS-1].v_q;
  assign sum       = g_stage[SEGS-1].s_q;
  assign cout      = g_stage[SEGS-1].c_q;
  assign zflag     = g_stage[SEGS-1].z_q;
  assign vflag     = g_stage[SEGS-1].g_last.vf_q;
  assign nflag     = sum[N-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub (N=32, SEGS=4); expectations follow PIPE_ADDSUB_SAT_EN.
module tb_pipe_addsub;
  localparam int N    = 32;
  localparam int SEGS = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   mode;
  logic         cin;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         vflag;
  logic         zflag;
  logic         nflag;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.N(N), .SEGS(SEGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .cin(cin), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .vflag(vflag), .zflag(zflag), .nflag(nflag)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one bundle, checks it is accepted, and returns #1 after the accept edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                               input logic c, input logic s);
    mode = m; a = av; b = bv; cin = c; sat = s; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic runOne(input string tag, input logic [1:0] m, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic s, input logic [31:0] es, input logic ec,
                        input logic ev, input logic ez, input logic en);
    int lat;
    out_ready = 1'b1;
    applyStimulus(m, av, bv, c, s);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, SEGS);
    @(negedge clk);
    checkOutput({tag, "_sum"}, sum, es);
    checkOutput({tag, "_cout"}, cout, ec);
    checkOutput({tag, "_vflag"}, vflag, ev);
    checkOutput({tag, "_zflag"}, zflag, ez);
    checkOutput({tag, "_nflag"}, nflag, en);
    @(posedge clk);
    #1;
    checkOutput({tag, "_bubble"}, out_valid, 1'b0);
  endtask

  function automatic logic [31:0] bpA(input int i);
    return 32'h00FF_FF00 + 32'h0101_0101 * i;
  endfunction

  function automatic logic [31:0] bpB(input int i);
    return 32'h0000_0100 * (i + 1);
  endfunction

  initial begin
    logic [31:0] expSum [8];
    logic [31:0] held;
    logic        stalled;
    logic        acc;
    int          sent;
    int          got;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 2'b00; cin = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_sum", sum, 32'h0);
    checkOutput("rst_flags", {cout, vflag, zflag, nflag}, 4'b0000);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    runOne("add_carry", 2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 0, 0, 0, 0);
    runOne("add_cin_ignored", 2'b00, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0002, 0, 0, 0, 0);
    runOne("sub_equal", 2'b01, 32'h5, 32'h5, 1'b0, 1'b0, 32'h0, 1, 0, 1, 0);
    runOne("sub_borrow", 2'b01, 32'h0, 32'h1, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    runOne("adc_wrap", 2'b10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1, 0, 1, 0);
    runOne("adc_cin0", 2'b10, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 0, 0, 0, 0);
    runOne("sbc_cin0", 2'b11, 32'h3, 32'h1, 1'b0, 1'b0, 32'h1, 1, 0, 0, 0);
    runOne("add_ovf_nosat", 2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
    runOne("add_sat_noovf", 2'b00, 32'h1, 32'h2, 1'b0, 1'b1, 32'h3, 0, 0, 0, 0);
`ifdef PIPE_ADDSUB_SAT_EN
    runOne("add_ovf_sat", 2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 0, 1, 0, 0);
    runOne("sub_ovf_sat", 2'b01, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1, 1, 0, 1);
`else
    runOne("add_ovf_sat", 2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 0, 1, 0, 1);
    runOne("sub_ovf_sat", 2'b01, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1, 1, 0, 0);
`endif

    // Back-to-back bundles with out_ready cycling 1,0,0,1.
    for (int i = 0; i < 8; i++) expSum[i] = bpA(i) + bpB(i);
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    mode = 2'b00; cin = 1'b0; sat = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      a = bpA(sent);
      b = bpB(sent);
      @(negedge clk);
      if (stalled) begin
        checkOutput("stall_hold_valid", out_valid, 1'b1);
        checkOutput("stall_hold_sum", sum, held);
      end
      if (out_valid) checkOutput("ready_match", in_ready, out_ready);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("bp_sum%0d", got), sum, expSum[got]);
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = sum;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checkOutput("bp_count", got, 8);
    @(negedge clk);
    checkOutput("bp_drained", out_valid, 1'b0);

    // Reset with one result at the output and three bundles behind it.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      mode = 2'b00; a = 32'h1000 + i; b = 32'h1; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_valid", out_valid, 1'b0);
    checkOutput("rst_mid_sum", sum, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_idle%0d", i), out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    runOne("after_rst", 2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
